tty_tx_ctrl: RTL

- Memory-mapped teleprinter/serial transmit controller on the cpu32 data bus. Selected when d_addr[31:28] == 4'hE.
- Buffers CPU byte writes in a FIFO and serialises them as 8N1 frames on txd, at a programmable bit period.
- Exposes status (full/empty/busy/overflow/count) so firmware can poll instead of blindly writing.

---
 rtl/cpu32_io_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/tty_tx_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cpu32_io_pkg.sv
// Shared definitions for cpu32 memory-mapped IO blocks.
//   IO_BASE       : d_addr[31:28] nibble that selects the IO region
//   REG_*         : register offsets as seen on d_addr[3:2]
//   STAT_*        : STATUS register bit positions
//   tx_state_t    : serial transmitter FSM states
package cpu32_io_pkg;

   localparam logic [3:0] IO_BASE = 4'hE;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DIV    = 2'd2;

   localparam int unsigned STAT_FULL    = 0;
   localparam int unsigned STAT_EMPTY   = 1;
   localparam int unsigned STAT_BUSY    = 2;
   localparam int unsigned STAT_OVF     = 3;
   localparam int unsigned STAT_CNT_LSB = 4;
   localparam int unsigned STAT_CNT_W   = 9;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a first-word-fall-through head.
//   clk, reset      : clock, asynchronous active-high reset
//   push, wdata     : write request and data
//   push_ok         : push is accepted this cycle (room, or a pop frees a slot)
//   pop             : remove the head entry (ignored when empty)
//   rdata           : current head entry, valid whenever empty = 0
//   count           : number of stored entries, 0..DEPTH
//   full, empty     : count == DEPTH, count == 0
module sync_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   output logic                     push_ok,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    head_q, head_d;
   logic [AW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic             pop_ok;

   assign full    = (count_q == DEPTH_C);
   assign empty   = (count_q == '0);
   assign pop_ok  = pop & ~empty;
   // A pop in the same cycle frees the slot the push lands in.
   assign push_ok = push & (~full | pop_ok);
   assign rdata   = mem[head_q];
   assign count   = count_q;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (pop_ok)  head_d = head_q + 1'b1;
      if (push_ok) tail_d = tail_q + 1'b1;
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset; the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[tail_q] <= wdata;
   end

endmodule

// File: rtl/tty_tx_ctrl.sv
// Memory-mapped 8N1 serial transmit controller for the cpu32 data bus.
// CPU byte writes are queued in a FIFO and sent LSB first at a programmable
// bit period of DIV+1 clocks.
//   clk, reset : clock, asynchronous active-high reset
//   cs, we     : chip select (IO region decoded outside), write strobe
//   addr       : register select (d_addr[3:2]): 0 DATA, 1 STATUS, 2 DIV
//   wdata      : write data
//   rdata      : combinational read data, 0 when not selected
//   txd        : registered serial output, idles high
//   irq_empty  : FIFO empty and transmitter idle
module tty_tx_ctrl
   import cpu32_io_pkg::*;
#(
   parameter int unsigned DEPTH     = 16,
   parameter logic [15:0] DIV_RESET = 16'd3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        txd,
   output logic        irq_empty
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic          wr;
   logic          push;
   logic          push_ok;
   logic          pop;
   logic [7:0]    head;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          busy;

   tx_state_t     state_q, state_d;
   logic [7:0]    sh_q, sh_d;
   logic [15:0]   div_q, div_d;      // divisor frozen for the current frame
   logic [15:0]   tmr_q, tmr_d;
   logic [2:0]    idx_q, idx_d;
   logic          txd_q, txd_d;
   logic [15:0]   div_reg_q, div_reg_d;
   logic          ovf_q, ovf_d;

   logic          unused_wdata;
   assign unused_wdata = ^wdata[31:16];

   assign wr   = cs & we;
   assign push = wr & (addr == REG_DATA);

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .wdata   (wdata[7:0]),
      .push_ok (push_ok),
      .pop     (pop),
      .rdata   (head),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         sh_q    <= '0;
         div_q   <= '0;
         tmr_q   <= '0;
         idx_q   <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         div_q   <= div_d;
         tmr_q   <= tmr_d;
         idx_q   <= idx_d;
         txd_q   <= txd_d;
      end
   end

   // FSM next state; each bit lasts while the timer runs div_q..0
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      div_d   = div_q;
      tmr_d   = tmr_q;
      idx_d   = idx_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               sh_d    = head;
               div_d   = div_reg_q;
               tmr_d   = div_reg_q;
               state_d = START;
            end
         end
         START: begin
            if (tmr_q == '0) begin
               tmr_d   = div_q;
               idx_d   = '0;
               state_d = DATA;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         DATA: begin
            if (tmr_q == '0) begin
               tmr_d = div_q;
               sh_d  = sh_q >> 1;
               if (idx_q == 3'd7) state_d = STOP;
               else               idx_d   = idx_q + 1'b1;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         STOP: begin
            if (tmr_q == '0) state_d = IDLE;
            else             tmr_d   = tmr_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs; txd is computed from the next state so the flop lines up
   // with the state it belongs to.
   always_comb begin
      busy  = (state_q != IDLE);
      txd_d = 1'b1;
      unique case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = sh_d[0];
         default: txd_d = 1'b1;
      endcase
   end

   assign txd       = txd_q;
   assign irq_empty = empty & (state_q == IDLE);

   // Bus-writable registers; an overflowing push beats a clear in the same cycle.
   always_comb begin
      div_reg_d = div_reg_q;
      ovf_d     = ovf_q;
      if (wr && addr == REG_DIV) div_reg_d = wdata[15:0];
      if (wr && addr == REG_STATUS && wdata[STAT_OVF]) ovf_d = 1'b0;
      if (push && !push_ok) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_reg_q <= DIV_RESET;
         ovf_q     <= 1'b0;
      end else begin
         div_reg_q <= div_reg_d;
         ovf_q     <= ovf_d;
      end
   end

   always_comb begin
      rdata = '0;
      if (cs) begin
         unique case (addr)
            REG_STATUS: begin
               rdata[STAT_FULL]  = full;
               rdata[STAT_EMPTY] = empty;
               rdata[STAT_BUSY]  = busy;
               rdata[STAT_OVF]   = ovf_q;
               rdata[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(count);
            end
            REG_DIV:  rdata[15:0] = div_reg_q;
            default:  rdata = '0;
         endcase
      end
   end

endmodule
